// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between ALU (A) and load (B) writeback.
// Rev 1.0 - one-entry buffer per requester, oldest-first drain, pending-write mask.
`default_nettype none

module regfile_write_arbiter #(
   parameter int REG_NUMBER       = 32,
   parameter int REG_ADDR_WIDTH   = $clog2(REG_NUMBER),
   parameter int REG_WIDTH_IN_BIT = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        a_valid,
   output logic                        a_ready,
   input  logic [REG_ADDR_WIDTH-1:0]   a_addr,
   input  logic [REG_WIDTH_IN_BIT-1:0] a_data,
   input  logic                        b_valid,
   output logic                        b_ready,
   input  logic [REG_ADDR_WIDTH-1:0]   b_addr,
   input  logic [REG_WIDTH_IN_BIT-1:0] b_data,
   output logic                        rf_write_enable,
   output logic [REG_ADDR_WIDTH-1:0]   rf_write_reg_addr,
   output logic [REG_WIDTH_IN_BIT-1:0] rf_write_data,
   output logic [REG_NUMBER-1:0]       pending_mask
);

   logic                        a_full, b_full;
   logic [REG_ADDR_WIDTH-1:0]   a_buf_addr, b_buf_addr;
   logic [REG_WIDTH_IN_BIT-1:0] a_buf_data, b_buf_data;
   // Set when the B entry was loaded strictly before the A entry.
   logic                        b_first;

   logic a_grant, b_grant, a_load, b_load, a_stay, b_stay;

   assign a_grant = a_full && (!b_full || !b_first);
   assign b_grant = b_full && (!a_full ||  b_first);

   // Ready is forced low while reset is asserted, independent of buffer state.
   assign a_ready = reset && (!a_full || a_grant);
   assign b_ready = reset && (!b_full || b_grant);

   assign a_load = a_valid && a_ready;
   assign b_load = b_valid && b_ready;
   assign a_stay = a_full && !a_grant;
   assign b_stay = b_full && !b_grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_full     <= 1'b0;
         b_full     <= 1'b0;
         a_buf_addr <= '0;
         b_buf_addr <= '0;
         a_buf_data <= '0;
         b_buf_data <= '0;
         b_first    <= 1'b0;
      end else begin
         a_full <= a_load || a_stay;
         b_full <= b_load || b_stay;
         if (a_load) begin
            a_buf_addr <= a_addr;
            a_buf_data <= a_data;
         end
         if (b_load) begin
            b_buf_addr <= b_addr;
            b_buf_data <= b_data;
         end
         // A wins ties when both load on the same edge.
         if (b_stay && a_load)
            b_first <= 1'b1;
         else if (a_load || b_load)
            b_first <= 1'b0;
      end
   end

   always_comb begin
      rf_write_enable   = 1'b0;
      rf_write_reg_addr = '0;
      rf_write_data     = '0;
      if (a_grant && a_buf_addr != '0) begin
         rf_write_enable   = 1'b1;
         rf_write_reg_addr = a_buf_addr;
         rf_write_data     = a_buf_data;
      end else if (b_grant && b_buf_addr != '0) begin
         rf_write_enable   = 1'b1;
         rf_write_reg_addr = b_buf_addr;
         rf_write_data     = b_buf_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      if (a_full) pending_mask[a_buf_addr] = 1'b1;
      if (b_full) pending_mask[b_buf_addr] = 1'b1;
      pending_mask[0] = 1'b0;
   end

endmodule

`default_nettype wire
